// File: rtl/usage_timer_pkg.sv
// usage_timer_pkg: shared constants, state encodings and time type for the usage timer reminder
package usage_timer_pkg;
  localparam int TICKS_PER_SEC = 100;
  localparam int BLINK_TICKS = 50;
  localparam int HOUR_MAX = 63;
  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [1:0] ST_STOPPED = 2'b00;
  localparam logic [1:0] ST_RUNNING = 2'b01;
  localparam logic [1:0] ST_ALERT = 2'b10;
  typedef struct packed {
    logic [5:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
  } hms_t;
endpackage

// File: rtl/usage_timer_reminder_if.sv
// usage_timer_reminder_if: control inputs, thresholds and accumulated-time/alert outputs of the reminder
interface usage_timer_reminder_if;
  logic run_en;
  logic clean_press_once;
  logic [5:0] hour_threshold;
  logic [5:0] min_threshold;
  logic [5:0] sec_threshold;
  logic [5:0] acc_hour;
  logic [5:0] acc_min;
  logic [5:0] acc_sec;
  logic [1:0] state;
  logic remind;
  logic remind_blink;
  modport master (
    output run_en, clean_press_once, hour_threshold, min_threshold, sec_threshold,
    input acc_hour, acc_min, acc_sec, state, remind, remind_blink
  );
  modport slave (
    input run_en, clean_press_once, hour_threshold, min_threshold, sec_threshold,
    output acc_hour, acc_min, acc_sec, state, remind, remind_blink
  );
endinterface

// File: rtl/hms_counter.sv
// hms_counter: hour/min/sec accumulator (clk, rst_n async low, clr beats inc), saturates at HOUR_MAX:59:59
module hms_counter #(
  parameter int HOUR_MAX = usage_timer_pkg::HOUR_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [5:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec
);
  import usage_timer_pkg::*;
  logic sec_wrap, min_wrap, sat;
  assign sec_wrap = sec == SEC_MAX;
  assign min_wrap = min == MIN_MAX;
  assign sat = hour == 6'(HOUR_MAX) && min_wrap && sec_wrap;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hour <= '0;
      min <= '0;
      sec <= '0;
    end else if (clr) begin
      hour <= '0;
      min <= '0;
      sec <= '0;
    end else if (inc && !sat) begin
      sec <= sec_wrap ? '0 : sec + 6'd1;
      if (sec_wrap) begin
        min <= min_wrap ? '0 : min + 6'd1;
        if (min_wrap) hour <= hour + 6'd1;
      end
    end
endmodule

// File: rtl/usage_timer_reminder.sv
// usage_timer_reminder: accumulates run time (clk_100Hz, rst_n async low, bus.slave) and latches a blinking clean reminder
module usage_timer_reminder #(
  parameter int TICKS_PER_SEC = usage_timer_pkg::TICKS_PER_SEC,
  parameter int BLINK_TICKS = usage_timer_pkg::BLINK_TICKS,
  parameter int HOUR_MAX = usage_timer_pkg::HOUR_MAX
) (
  input logic clk_100Hz,
  input logic rst_n,
  usage_timer_reminder_if.slave bus
);
  import usage_timer_pkg::*;
  logic [6:0] tick_cnt, blink_cnt;
  logic [1:0] state, state_nxt;
  logic sec_tick, reached, run, clean, remind, blink;
  hms_t acc, thr;
  assign run = bus.run_en;
  assign clean = bus.clean_press_once;
  assign thr = {bus.hour_threshold, bus.min_threshold, bus.sec_threshold};
  assign sec_tick = run && tick_cnt == 7'(TICKS_PER_SEC - 1);
  // packed h:m:s compares lexicographically as one vector; zero threshold disables
  assign reached = thr != '0 && acc >= thr;
  hms_counter #(.HOUR_MAX(HOUR_MAX)) u_hms (
    .clk(clk_100Hz),
    .rst_n(rst_n),
    .clr(clean),
    .inc(sec_tick),
    .hour(acc.hour),
    .min(acc.min),
    .sec(acc.sec)
  );
  always_comb
    state_nxt = clean ? (run ? ST_RUNNING : ST_STOPPED)
              : (state == ST_ALERT || reached) ? ST_ALERT
              : run ? ST_RUNNING : ST_STOPPED;
  always_ff @(posedge clk_100Hz or negedge rst_n)
    if (!rst_n) begin
      tick_cnt <= '0;
      state <= ST_STOPPED;
      remind <= 1'b0;
    end else begin
      tick_cnt <= clean ? '0 : run ? (sec_tick ? '0 : tick_cnt + 7'd1) : tick_cnt;
      state <= state_nxt;
      remind <= state_nxt == ST_ALERT;
    end
  // blink phase restarts on every ALERT entry since it is held at 0 outside ALERT
  always_ff @(posedge clk_100Hz or negedge rst_n)
    if (!rst_n) begin
      blink_cnt <= '0;
      blink <= 1'b0;
    end else if (clean || state != ST_ALERT) begin
      blink_cnt <= '0;
      blink <= 1'b0;
    end else if (blink_cnt == 7'(BLINK_TICKS - 1)) begin
      blink_cnt <= '0;
      blink <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + 7'd1;
    end
  assign bus.acc_hour = acc.hour;
  assign bus.acc_min = acc.min;
  assign bus.acc_sec = acc.sec;
  assign bus.state = state;
  assign bus.remind = remind;
  assign bus.remind_blink = blink;
endmodule
